// File: rtl/ahb2apb_bridge_p.sv
// rtl/ahb2apb_bridge_p.sv - parametrised AHB-Lite to APB bridge with wait states, slave errors, strobes and timeout
module ahb2apb_bridge_p #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = 2,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [ADDR_W-1:0]   HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADYin,
    output logic                HREADYout,
    output logic [1:0]          HRESP,
    output logic [DATA_W-1:0]   HRDATA,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic                PWRITE,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int MAX_SIZE = $clog2(STRB_W);
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [SEL_W-1:0]  req_idx;
    logic [7:0]        addr_lo;
    logic [7:0]        align_mask;
    logic [STRB_W-1:0] lanes;
    logic              accept;
    logic              illegal;
    logic              timed_out;

    assign req_idx    = HADDR[SEL_LSB +: SEL_W];
    assign addr_lo    = HADDR[7:0];
    assign align_mask = (8'd1 << HSIZE) - 8'd1;
    // Lane mask of 2^HSIZE bytes shifted to the byte offset within the data bus.
    assign lanes      = STRB_W'(((16'd1 << (16'd1 << HSIZE)) - 16'd1) << (addr_lo & 8'(STRB_W - 1)));

    assign accept  = (state == S_IDLE || state == S_DONE || state == S_ERR2) && HREADYin && HTRANS[1];
    assign illegal = ({1'b0, req_idx} >= (SEL_W+1)'(NUM_SLV))
                   || (int'(HSIZE) > MAX_SIZE)
                   || (|(addr_lo & align_mask));
    // PREADY in the expiring cycle still completes the transfer normally.
    assign timed_out = (TIMEOUT > 0) && !PREADY && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept)
                    state_nxt = illegal ? S_ERR1 : (HWRITE ? S_WDATA : S_SETUP);
                else
                    state_nxt = S_IDLE;
            end
            S_WDATA:  state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (PREADY)
                    state_nxt = PSLVERR ? S_ERR1 : S_DONE;
                else if (timed_out)
                    state_nxt = S_ERR1;
            end
            S_ERR1:   state_nxt = S_ERR2;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        HREADYout = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
        HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
        PENABLE   = (state == S_ACCESS);
        PSEL      = '0;
        for (int i = 0; i < NUM_SLV; i++)
            PSEL[i] = (state == S_SETUP || state == S_ACCESS) && (sel_idx == SEL_W'(i));
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            sel_idx <= '0;
            tmo_cnt <= '0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PWRITE  <= 1'b0;
            HRDATA  <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !illegal) begin
                PADDR   <= HADDR;
                PWRITE  <= HWRITE;
                PSTRB   <= HWRITE ? lanes : '0;
                sel_idx <= req_idx;
            end
            if (state == S_WDATA)
                PWDATA <= HWDATA;
            if (state == S_SETUP)
                tmo_cnt <= '0;
            else if (state == S_ACCESS && !PREADY)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == S_ACCESS && PREADY && !PSLVERR && !PWRITE)
                HRDATA <= PRDATA;
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// tb/tb_ahb2apb_bridge_p.sv - scoreboard bench for ahb2apb_bridge_p (default and 3-slave/timeout builds)
module tb_ahb2apb_bridge_p;
    logic        HCLK, HRESET;
    logic [31:0] HADDR, HWDATA, PRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADYin, PREADY, PSLVERR;
    logic [2:0]  HSIZE;

    logic        hready0, hready1, pwrite0, pwrite1, penable0, penable1;
    logic [1:0]  hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1, paddr0, paddr1, pwdata0, pwdata1;
    logic [3:0]  pstrb0, pstrb1, psel0;
    logic [2:0]  psel1;

    bit          sel;
    logic        hready_o, pwrite_o, penable_o;
    logic [1:0]  hresp_o;
    logic [31:0] hrdata_o, paddr_o, pwdata_o;
    logic [3:0]  pstrb_o, psel_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_rdata;

    typedef struct {
        int          waits;
        logic [1:0]  resp;
        logic [3:0]  psel;
        logic [31:0] paddr;
        logic [3:0]  pstrb;
        logic        pwrite;
        logic [31:0] pwdata;
        int          pen;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    ahb2apb_bridge_p u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYin(HREADYin), .HREADYout(hready0),
        .HRESP(hresp0), .HRDATA(hrdata0), .PADDR(paddr0), .PWDATA(pwdata0), .PSTRB(pstrb0),
        .PWRITE(pwrite0), .PSEL(psel0), .PENABLE(penable0), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    ahb2apb_bridge_p #(.NUM_SLV(3), .TIMEOUT(4)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYin(HREADYin), .HREADYout(hready1),
        .HRESP(hresp1), .HRDATA(hrdata1), .PADDR(paddr1), .PWDATA(pwdata1), .PSTRB(pstrb1),
        .PWRITE(pwrite1), .PSEL(psel1), .PENABLE(penable1), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always_comb begin
        hready_o  = sel ? hready1  : hready0;
        hresp_o   = sel ? hresp1   : hresp0;
        hrdata_o  = sel ? hrdata1  : hrdata0;
        paddr_o   = sel ? paddr1   : paddr0;
        pwdata_o  = sel ? pwdata1  : pwdata0;
        pstrb_o   = sel ? pstrb1   : pstrb0;
        pwrite_o  = sel ? pwrite1  : pwrite0;
        psel_o    = sel ? {1'b0, psel1} : psel0;
        penable_o = sel ? penable1 : penable0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int waits, input logic [1:0] resp, input logic [3:0] psel,
                                input logic [31:0] paddr, input logic [3:0] pstrb, input logic pwrite,
                                input logic [31:0] pwdata, input int pen, input logic [31:0] rdata);
        exp_t e;
        e.waits = waits; e.resp = resp; e.psel = psel; e.paddr = paddr; e.pstrb = pstrb;
        e.pwrite = pwrite; e.pwdata = pwdata; e.pen = pen; e.rdata = rdata;
        return e;
    endfunction

    // Starts the address phase immediately, so a call made in a DONE/ERR2 cycle is back-to-back.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input int nwait, input logic slverr,
                        input logic [31:0] rdata, input exp_t e);
        int low = 0, pen = 0, acc = 0;
        bit done = 0, got = 0, unstable = 0;
        logic [1:0]  resp_low = 2'b00, resp_fin;
        logic [3:0]  c_psel = '0, c_pstrb = '0;
        logic [31:0] c_paddr = '0, c_pwdata = '0;
        logic        c_pwrite = 1'b0;
        exp_t x;
        sb.push_back(e);
        HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HREADYin = 1'b1; PRDATA = rdata;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HWDATA = wdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge HCLK);
            if (hready_o) done = 1;
            else begin
                low++;
                resp_low = hresp_o;
                if (psel_o != 0 && !got) begin
                    got = 1; c_psel = psel_o; c_paddr = paddr_o; c_pstrb = pstrb_o;
                    c_pwdata = pwdata_o; c_pwrite = pwrite_o;
                end else if (psel_o != 0) begin
                    if (psel_o !== c_psel || paddr_o !== c_paddr || pstrb_o !== c_pstrb ||
                        pwdata_o !== c_pwdata || pwrite_o !== c_pwrite) unstable = 1;
                end
                if (penable_o) begin
                    pen++;
                    PREADY = (acc >= nwait);
                    PSLVERR = slverr && PREADY;
                    acc++;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0;
                end
            end
        end
        resp_fin = hresp_o;
        PREADY = 1'b0; PSLVERR = 1'b0;
        check({tag, ".completed"}, done, 1);
        check({tag, ".sb_depth"}, sb.size(), 1);
        x = sb.pop_front();
        check({tag, ".wait_cycles"}, low, x.waits);
        check({tag, ".hresp_last_wait"}, resp_low, x.resp);
        check({tag, ".hresp_final"}, resp_fin, x.resp);
        check({tag, ".psel"}, c_psel, x.psel);
        check({tag, ".penable_cycles"}, pen, x.pen);
        check({tag, ".hrdata"}, hrdata_o, x.rdata);
        if (x.psel != 0) begin
            check({tag, ".paddr"}, c_paddr, x.paddr);
            check({tag, ".pstrb"}, c_pstrb, x.pstrb);
            check({tag, ".pwrite"}, c_pwrite, x.pwrite);
            check({tag, ".apb_stable"}, unstable, 0);
            if (x.pwrite) check({tag, ".pwdata"}, c_pwdata, x.pwdata);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".hready"}, hready_o, 1);
        check({tag, ".hresp"}, hresp_o, 0);
        check({tag, ".psel"}, psel_o, 0);
        check({tag, ".penable"}, penable_o, 0);
        check({tag, ".pwrite"}, pwrite_o, 0);
        check({tag, ".paddr"}, paddr_o, 0);
        check({tag, ".pwdata"}, pwdata_o, 0);
        check({tag, ".pstrb"}, pstrb_o, 0);
        check({tag, ".hrdata"}, hrdata_o, 0);
    endtask

    initial begin
        sel = 0;
        HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = '0;
        HREADYin = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; last_rdata = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs("por");
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        xfer("wr_word", 32'h0000_1004, 1, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h0,
             mk(3, 2'b00, 4'b0010, 32'h1004, 4'b1111, 1, 32'hDEAD_BEEF, 1, last_rdata));
        last_rdata = 32'h1234_5678;
        xfer("rd_wait3", 32'h0000_3000, 0, 3'd2, 32'h0, 3, 0, 32'h1234_5678,
             mk(5, 2'b00, 4'b1000, 32'h3000, 4'b0000, 0, 32'h0, 4, last_rdata));
        xfer("wr_byte", 32'h0000_0002, 1, 3'd0, 32'h00AB_0000, 0, 0, 32'h0,
             mk(3, 2'b00, 4'b0001, 32'h0002, 4'b0100, 1, 32'h00AB_0000, 1, last_rdata));
        xfer("wr_half_misaligned", 32'h0000_0001, 1, 3'd1, 32'h5555_5555, 0, 0, 32'h0,
             mk(1, 2'b01, 4'b0000, 32'h0, 4'b0000, 1, 32'h0, 0, last_rdata));
        xfer("rd_pslverr", 32'h0000_2010, 0, 3'd2, 32'h0, 0, 1, 32'hFFFF_FFFF,
             mk(3, 2'b01, 4'b0100, 32'h2010, 4'b0000, 0, 32'h0, 1, last_rdata));
        xfer("rd_oversize", 32'h0000_0000, 0, 3'd3, 32'h0, 0, 0, 32'h0,
             mk(1, 2'b01, 4'b0000, 32'h0, 4'b0000, 0, 32'h0, 0, last_rdata));
        xfer("wr_half_upper", 32'h0000_0006, 1, 3'd1, 32'hBEEF_0000, 1, 0, 32'h0,
             mk(4, 2'b00, 4'b0001, 32'h0006, 4'b1100, 1, 32'hBEEF_0000, 2, last_rdata));

        // Reset asserted while a read sits in ACCESS with PREADY low.
        HADDR = 32'h0000_2000; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        @(posedge HCLK); #1;
        check("midrst.penable_before", penable_o, 1);
        check("midrst.psel_before", psel_o, 4'b0100);
        HRESET = 1'b1;
        @(negedge HCLK);
        check_reset_outputs("midrst");
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        last_rdata = '0;
        @(posedge HCLK); #1;

        sel = 1;
        xfer("decode_err", 32'h0000_3000, 0, 3'd2, 32'h0, 0, 0, 32'h0,
             mk(1, 2'b01, 4'b0000, 32'h0, 4'b0000, 0, 32'h0, 0, last_rdata));
        xfer("timeout", 32'h0000_2000, 0, 3'd2, 32'h0, 99, 0, 32'h7777_7777,
             mk(6, 2'b01, 4'b0100, 32'h2000, 4'b0000, 0, 32'h0, 4, last_rdata));
        last_rdata = 32'hCAFE_F00D;
        xfer("b2b_after_err", 32'h0000_1008, 0, 3'd2, 32'h0, 1, 0, 32'hCAFE_F00D,
             mk(3, 2'b00, 4'b0010, 32'h1008, 4'b0000, 0, 32'h0, 2, last_rdata));
        last_rdata = 32'h0BAD_CAFE;
        xfer("ready_at_timeout", 32'h0000_2004, 0, 3'd2, 32'h0, 3, 0, 32'h0BAD_CAFE,
             mk(5, 2'b00, 4'b0100, 32'h2004, 4'b0000, 0, 32'h0, 4, last_rdata));

        @(posedge HCLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
